// File: rtl/text_cmd_sequencer.sv
// text_cmd_sequencer
//   Command FIFO plus issue sequencer in front of the text buffer stage.
//   24-bit commands (opcode in [23:16]) are queued and issued at most one per
//   cycle. Opcode 253 (flush) is forwarded and then holds issue until the text
//   buffer reports completion. Opcode 254 (clear) is not forwarded; instead it
//   expands into a COLS x ROWS sweep of per-cell clear strobes.
//
//   Optional feature macro: TXTSEQ_TIMEOUT_EN
//     defined   -> an 11-bit watchdog abandons a flush wait after 2047 cycles
//                  and raises sticky tmo.
//     undefined -> flush wait is unbounded and tmo is tied low.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-low reset
//   cmd_in     command word from CPU bus
//   cmd_wr     push strobe
//   cmd_full   FIFO full (combinational)
//   cmd_count  FIFO occupancy (combinational)
//   ovf        sticky: a push was dropped on a full FIFO
//   out        command word to text buffer
//   start      command strobe to text buffer
//   clearx     clear column to text buffer
//   cleary     clear row to text buffer
//   flush_irq  flush-complete pulse from text buffer
//   busy       sequencer not idle or FIFO non-empty (combinational)
//   irq        one-cycle pulse with the final clear strobe
//   tmo        sticky flush-timeout flag
module text_cmd_sequencer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned COLS  = 43,
  parameter int unsigned ROWS  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [23:0]              cmd_in,
  input  logic                     cmd_wr,
  output logic                     cmd_full,
  output logic [$clog2(DEPTH):0]   cmd_count,
  output logic                     ovf,
  output logic [23:0]              out,
  output logic                     start,
  output logic [5:0]               clearx,
  output logic [4:0]               cleary,
  input  logic                     flush_irq,
  output logic                     busy,
  output logic                     irq,
  output logic                     tmo
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [7:0]  OP_FLUSH = 8'd253;
  localparam logic [7:0]  OP_CLEAR = 8'd254;
  localparam logic [23:0] CLR_WORD = {OP_CLEAR, 16'd0};
  localparam logic [5:0]  LAST_X   = 6'(COLS - 1);
  localparam logic [4:0]  LAST_Y   = 5'(ROWS - 1);
  // A 1x1 screen finishes on the very first clear cell.
  localparam logic        ONE_CELL = 1'((COLS == 1) && (ROWS == 1));

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FLUSH = 2'd1,
    S_CLEAR      = 2'd2
  } state_t;

  state_t state_q, state_d;

  // FIFO storage and pointers
  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          empty;
  logic          push;
  logic          pop;
  logic [23:0]   head;

  // Next values for registered outputs
  logic [23:0] out_d;
  logic        start_d;
  logic [5:0]  clearx_d;
  logic [4:0]  cleary_d;
  logic        irq_d;
  logic        clear_last;

  assign empty     = (count_q == '0);
  assign cmd_full  = (count_q == CW'(DEPTH));
  assign cmd_count = count_q;
  // A pop in the same cycle never frees a slot for a push to a full FIFO.
  assign push      = cmd_wr && !cmd_full;
  assign head      = mem[rd_ptr_q];
  assign busy      = (state_q != S_IDLE) || !empty;
  // In CLEAR the output registers always hold the cell being emitted.
  assign clear_last = (clearx == LAST_X) && (cleary == LAST_Y);

`ifdef TXTSEQ_TIMEOUT_EN
  localparam logic [10:0] TMO_LAST = 11'd2046;
  logic [10:0] tmo_cnt_q;
  logic        tmo_set;
  logic        tmo_q;
`endif

  // Next-state and next-output decode
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    out_d    = '0;
    start_d  = 1'b0;
    clearx_d = '0;
    cleary_d = '0;
    irq_d    = 1'b0;
`ifdef TXTSEQ_TIMEOUT_EN
    tmo_set  = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          unique case (head[23:16])
            OP_FLUSH: begin
              out_d   = head;
              start_d = 1'b1;
              state_d = S_WAIT_FLUSH;
            end
            OP_CLEAR: begin
              out_d   = CLR_WORD;
              start_d = 1'b1;
              irq_d   = ONE_CELL;
              state_d = S_CLEAR;
            end
            default: begin
              out_d   = head;
              start_d = 1'b1;
            end
          endcase
        end
      end
      S_WAIT_FLUSH: begin
        if (flush_irq) begin
          state_d = S_IDLE;
        end
`ifdef TXTSEQ_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          state_d = S_IDLE;
          tmo_set = 1'b1;
        end
`endif
      end
      S_CLEAR: begin
        if (clear_last) begin
          // Final strobe already out; sweep ends with outputs idle.
          state_d = S_IDLE;
        end else begin
          out_d   = CLR_WORD;
          start_d = 1'b1;
          if (clearx == LAST_X) begin
            clearx_d = '0;
            cleary_d = 5'(cleary + 5'd1);
          end else begin
            clearx_d = 6'(clearx + 6'd1);
            cleary_d = cleary;
          end
          irq_d = (clearx_d == LAST_X) && (cleary_d == LAST_Y);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      out     <= '0;
      start   <= 1'b0;
      clearx  <= '0;
      cleary  <= '0;
      irq     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      out     <= out_d;
      start   <= start_d;
      clearx  <= clearx_d;
      cleary  <= cleary_d;
      irq     <= irq_d;
      if (cmd_wr && cmd_full) begin
        ovf <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= AW'(wr_ptr_q + 1'b1);
      end
      if (pop) begin
        rd_ptr_q <= AW'(rd_ptr_q + 1'b1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= CW'(count_q + 1'b1);
        2'b01:   count_q <= CW'(count_q - 1'b1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage array (no reset needed; occupancy gates reads)
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= cmd_in;
    end
  end

`ifdef TXTSEQ_TIMEOUT_EN
  // Flush watchdog: held at zero outside WAIT_FLUSH, so it starts at zero on entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      if (state_q == S_WAIT_FLUSH) begin
        tmo_cnt_q <= 11'(tmo_cnt_q + 11'd1);
      end else begin
        tmo_cnt_q <= '0;
      end
      if (tmo_set) begin
        tmo_q <= 1'b1;
      end
    end
  end

  assign tmo = tmo_q;
`else
  assign tmo = 1'b0;
`endif

endmodule

// File: doc/text_cmd_sequencer.md
# text_cmd_sequencer

Command queue and sequencer upstream of the text buffer stage. It accepts 24-bit graphics commands (opcode in [23:16]) from the CPU bus into a FIFO and issues them to the text buffer at most one per cycle. It holds issue while a buffer flush (opcode 253) is in progress, and expands a clear request (opcode 254) into a full-screen sweep of per-cell clear commands with matching `clearx`/`cleary`.

## Interface
Parameters:
- DEPTH, 16: FIFO entries; power of two, ≥ 2.
- COLS, 43: text columns swept by clear (x = 0..COLS-1).
- ROWS, 32: text rows swept by clear (y = 0..ROWS-1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cmd_in  in  24  command word from CPU bus.
- cmd_wr  in  1  push strobe; one command per cycle when high.
- cmd_full  out  1  FIFO full; combinational from count.
- cmd_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- ovf  out  1  sticky: a push was dropped because the FIFO was full.
- out  out  24  command to text buffer `in`.
- start  out  1  command strobe to text buffer `start`.
- clearx  out  6  clear column to text buffer.
- cleary  out  5  clear row to text buffer.
- flush_irq  in  1  flush-complete pulse from text buffer `irq`.
- busy  out  1  high in any state other than IDLE, or FIFO non-empty.
- irq  out  1  one-cycle pulse when a clear sweep finishes.
- tmo  out  1  sticky flush-timeout flag; tied 0 unless TXTSEQ_TIMEOUT_EN is defined.

## Operation
- Reset (rst=0): FIFO emptied; state IDLE. `out`, `start`, `clearx`, `cleary`, `irq`, `ovf`, `tmo` = 0. `cmd_count` = 0.
- FIFO push:
  - `cmd_wr` && !`cmd_full` writes `cmd_in`.
  - `cmd_wr` && `cmd_full` drops the word and sets `ovf`. A pop in the same cycle does not make room.
- Simultaneous push and pop: count is unchanged. Pointers wrap modulo DEPTH.
- States: IDLE, WAIT_FLUSH, CLEAR. Timeout below is macro-dependent.
- IDLE, FIFO non-empty: pop the head, then decode:
  - opcode 253: issue `out`=word, `start`=1; go WAIT_FLUSH.
  - opcode 254: do not forward the raw word; go CLEAR with x=0, y=0, and issue the first clear cell in the same edge.
  - any other opcode: issue unchanged with `start`=1; stay IDLE.
- WAIT_FLUSH: no pops. `flush_irq`=1 returns to IDLE. `flush_irq` is ignored in IDLE and CLEAR.
- CLEAR: each cycle emit `out`={8'd254,16'd0}, `start`=1, `clearx`=x, `cleary`=y.
  - Advance order: x increments first; when x=COLS-1, x resets to 0 and y increments.
  - Cell (COLS-1, ROWS-1) is emitted with `irq`=1 in the same cycle; next state IDLE.
  - Total COLS×ROWS strobes (1376 by default). No pops during CLEAR.
- When `start`=0: `out`=0, `clearx`=0, `cleary`=0.
- Reset asserted mid-flush or mid-sweep aborts immediately. No residual strobes; queued commands are lost.

## Timing
- All outputs except `cmd_full`, `cmd_count`, `busy` are registered.
- Latency, empty FIFO in IDLE: push at edge N, pop at edge N+1, `start` high during cycle after N+1 (2 cycles).
- Throughput: one forwarded command per cycle for back-to-back non-253/254 opcodes.
- `start` is a single-cycle pulse per command, except during CLEAR, where it stays high continuously.
- Flush hold:
  - `flush_irq` sampled high at edge M moves the state to IDLE.
  - The next pop occurs at edge M+1 at the earliest, so its `start` appears 2 cycles after the `flush_irq` cycle.
  - `flush_irq` coincident with the 253 issue edge is ignored.
- `irq` is high for exactly one cycle, concurrent with the final clear strobe.

## Configuration
- TXTSEQ_TIMEOUT_EN defined: an 11-bit counter runs in WAIT_FLUSH.
  - If 2047 cycles elapse without `flush_irq`, return to IDLE and set sticky `tmo` (cleared only by reset).
  - The counter zeroes on entering WAIT_FLUSH.
- Not defined: WAIT_FLUSH waits indefinitely; `tmo`=0 constantly; no counter logic.

## Test plan
- Reset: hold rst=0 with `cmd_wr`=1 -> all outputs 0, count 0. Release -> `start`=0 until first push.
- Burst: push 0x0A0018, 0x0B0010, 0x0C0041 back-to-back -> three consecutive `start` cycles, words in order, first 2 cycles after first push.
- Overflow: push 17 words with no pops possible (hold in WAIT_FLUSH) -> `cmd_full`=1 at 16, `ovf`=1, 17th word never issued.
- Flush hold: push 0xFD0000 then 0x0A0008 -> 0xFD0000 issued; 0x0A0008 held until `flush_irq` pulse, then issued 2 cycles after it.
- Clear: push 0xFE0000 -> 1376 consecutive strobes of 0xFE0000; first (0,0), second (1,0), 44th (0,1), last (42,31) with `irq`=1; `busy` falls next cycle.
- Timeout (macro on): push 0xFD0000, never pulse `flush_irq` -> after 2047 cycles `tmo`=1 and the next queued command issues.
